// File: rtl/pbmve_top_if.sv
// Motion-vector bus between a vector source (master) and pbmve_top (slave).
// Carries the per-block vector strobe, components and block address, plus
// the block-request and field-complete handshakes back to the source.
interface pbmve_top_if #(
  parameter int MV_W = 8
) ();
  logic            Vector_sig;
  logic [MV_W-1:0] mv_x;
  logic [MV_W-1:0] mv_y;
  logic [7:0]      addr_x;
  logic [7:0]      addr_y;
  logic            Nxt_block_sig;
  logic            MVF_complete_sig;

  modport master (
    output Vector_sig, mv_x, mv_y, addr_x, addr_y,
    input  Nxt_block_sig, MVF_complete_sig
  );

  modport slave (
    input  Vector_sig, mv_x, mv_y, addr_x, addr_y,
    output Nxt_block_sig, MVF_complete_sig
  );
endinterface

// File: rtl/pbmve_top.sv
// Motion-vector-field collector. Stores one {mv_x, mv_y} per block of a
// width x height grid, requests each next block with Nxt_block_sig and raises
// MVF_complete_sig once every grid position holds a vector.
// Optional feature macro: PBMVE_SLOW_PACE_EN -- paces Nxt_block_sig pulses
// to rising edges of the Slow_clk strobe (default build ignores Slow_clk).
module pbmve_top #(
  parameter int MAX_DIM = 16,
  parameter int MV_W    = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       enable,
  input  logic       Slow_clk,
  input  logic [7:0] height,
  input  logic [7:0] width,
  pbmve_top_if.slave bus
);
  localparam int         DEPTH     = MAX_DIM * MAX_DIM;
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         CNT_W     = $clog2(DEPTH + 1);
  localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state_q;
  state_t              next_state;

  logic [2*MV_W-1:0]   mvf_mem [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [CNT_W-1:0]    count;
  logic                vs_q;
  logic [7:0]          w_q;
  logic [7:0]          h_q;
  logic [CNT_W-1:0]    area_q;
  logic                nxt_q;

  logic                dims_ok;
  logic                accept;
  logic                in_range;
  logic                hit;
  logic                is_new;
  logic                last_vec;
  logic                start;
  logic                req;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    count_next;
  logic [15:0]         area_full;

  assign dims_ok   = (width  != 8'd0) && (width  <= MAX_DIM_B) &&
                     (height != 8'd0) && (height <= MAX_DIM_B);
  assign area_full = 16'(width) * 16'(height);
  assign idx       = IDX_W'(bus.addr_y) * IDX_W'(MAX_DIM) + IDX_W'(bus.addr_x);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) is reserved for combinational blocks.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Next-state logic: enable low always returns to IDLE.
  always_comb begin
    // NOTE: assigning a default first keeps always_comb from inferring a latch.
    next_state = state_q;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (dims_ok)  next_state = COLLECT;
        COLLECT: if (last_vec) next_state = DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Decode acceptance events and the block requests they generate.
  always_comb begin
    accept     = bus.Vector_sig & ~vs_q;
    in_range   = (bus.addr_x < w_q) && (bus.addr_y < h_q);
    hit        = (state_q == COLLECT) && enable && accept && in_range;
    is_new     = hit && !valid[idx];
    count_next = count + CNT_W'(is_new);
    last_vec   = hit && (count_next == area_q);
    start      = (state_q == IDLE) && enable && dims_ok;
    req        = start || (hit && !last_vec);
  end

  // Strobe history, dimension latch, occupancy bitmap and fill counter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b0;
      valid  <= '0;
      count  <= '0;
      w_q    <= '0;
      h_q    <= '0;
      area_q <= '0;
    end else begin
      vs_q <= bus.Vector_sig;
      if (start) begin
        w_q    <= width;
        h_q    <= height;
        area_q <= CNT_W'(area_full);
      end
      if (state_q == IDLE) begin
        valid <= '0;
        count <= '0;
      end else if (is_new) begin
        valid[idx] <= 1'b1;
        count      <= count_next;
      end
    end
  end

  // Vector storage; duplicates simply overwrite.
  // NOTE: the memory has no reset -- the valid bitmap decides which entries
  // mean anything, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (hit) mvf_mem[idx] <= {bus.mv_x, bus.mv_y};
  end

`ifdef PBMVE_SLOW_PACE_EN
  logic [2:0] slow_sync;
  logic       slow_tick;
  logic       pending;

  assign slow_tick = slow_sync[1] & ~slow_sync[2];

  // Synchronize Slow_clk, hold one pending request, release it after a tick.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      slow_sync <= '0;
      pending   <= 1'b0;
      nxt_q     <= 1'b0;
    end else begin
      slow_sync <= {slow_sync[1:0], Slow_clk};
      if (!enable) begin
        pending <= 1'b0;
        nxt_q   <= 1'b0;
      end else begin
        nxt_q   <= pending & slow_tick;
        pending <= (pending & ~slow_tick) | req;
      end
    end
  end
`else
  logic unused_slow_clk;
  assign unused_slow_clk = Slow_clk;

  // Registered one-cycle request pulse.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) nxt_q <= 1'b0;
    else       nxt_q <= req;
  end
`endif

  assign bus.Nxt_block_sig    = nxt_q;
  assign bus.MVF_complete_sig = (state_q == DONE);
endmodule

// File: tb/tb_pbmve_top.sv
// Self-checking bench for pbmve_top: a table of directed vectors, hand-written
// multi-cycle sequences, and randomized fields checked against a field model.
module tb_pbmve_top;
  logic       CLK = 1'b0;
  logic       reset;
  logic       enable;
  logic       Slow_clk;
  logic [7:0] height;
  logic [7:0] width;

  pbmve_top_if bus ();

  pbmve_top dut (
    .CLK     (CLK),
    .reset   (reset),
    .enable  (enable),
    .Slow_clk(Slow_clk),
    .height  (height),
    .width   (width),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Field model: what a collected field should look like.
  logic [15:0] m_mem   [256];
  bit          m_known [256];
  bit          m_valid [256];
  int          m_cnt;
  int          m_w;
  int          m_h;
  bit          m_done;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] mx;
    logic [7:0] my;
    bit         pulse;
    int         cnt;
    int         idx;
    logic [15:0] mem;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic void model_start(int w, int h);
    m_w = w;
    m_h = h;
    m_cnt = 0;
    m_done = 0;
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
  endfunction

  // Returns whether a block request is expected for this vector.
  function automatic bit model_vec(int x, int y, logic [7:0] mx, logic [7:0] my);
    int a;
    if (m_done || x >= m_w || y >= m_h) return 0;
    a = y * 16 + x;
    m_mem[a] = {mx, my};
    m_known[a] = 1;
    if (!m_valid[a]) begin
      m_valid[a] = 1;
      m_cnt++;
    end
    if (m_cnt == m_w * m_h) begin
      m_done = 1;
      return 0;
    end
    return 1;
  endfunction

  task automatic drive_vec(int x, int y, logic [7:0] mx, logic [7:0] my);
    bus.addr_x = 8'(x);
    bus.addr_y = 8'(y);
    bus.mv_x = mx;
    bus.mv_y = my;
    bus.Vector_sig = 1'b1;
  endtask

  task automatic start_field(int w, int h, string tag);
    enable = 1'b0;
    width = 8'(w);
    height = 8'(h);
    step();
    model_start(w, h);
    enable = 1'b1;
    step();
    check({tag, "_req"}, 32'(bus.Nxt_block_sig), 1);
    check({tag, "_nodone"}, 32'(bus.MVF_complete_sig), 0);
    step();
    check({tag, "_req_end"}, 32'(bus.Nxt_block_sig), 0);
  endtask

  task automatic send_vec(int x, int y, logic [7:0] mx, logic [7:0] my,
                          string tag, output bit got);
    bit ep;
    ep = model_vec(x, y, mx, my);
    drive_vec(x, y, mx, my);
    step();
    got = bus.Nxt_block_sig;
    check({tag, "_pulse"}, 32'(bus.Nxt_block_sig), 32'(ep));
    check({tag, "_done"}, 32'(bus.MVF_complete_sig), 32'(m_done));
    check({tag, "_count"}, 32'(dut.count), 32'(m_cnt));
    bus.Vector_sig = 1'b0;
    step();
    check({tag, "_gap"}, 32'(bus.Nxt_block_sig), 0);
  endtask

  initial begin
    vec_t tbl [9];
    bit   got;
    int   pulses;
    int   w;
    int   h;

    tbl[0] = '{x:1, y:1, mx:8'h01, my:8'h01, pulse:1, cnt:1, idx:17, mem:16'h0101};
    tbl[1] = '{x:1, y:1, mx:8'h7f, my:8'h80, pulse:1, cnt:1, idx:17, mem:16'h7f80};
    tbl[2] = '{x:5, y:0, mx:8'haa, my:8'hbb, pulse:0, cnt:1, idx:-1, mem:16'h0};
    tbl[3] = '{x:0, y:5, mx:8'hcc, my:8'hdd, pulse:0, cnt:1, idx:-1, mem:16'h0};
    tbl[4] = '{x:4, y:4, mx:8'hff, my:8'hfe, pulse:1, cnt:2, idx:68, mem:16'hfffe};
    tbl[5] = '{x:0, y:0, mx:8'h80, my:8'h7f, pulse:1, cnt:3, idx:0,  mem:16'h807f};
    tbl[6] = '{x:4, y:0, mx:8'h12, my:8'h34, pulse:1, cnt:4, idx:4,  mem:16'h1234};
    tbl[7] = '{x:0, y:4, mx:8'h56, my:8'h78, pulse:1, cnt:5, idx:64, mem:16'h5678};
    tbl[8] = '{x:7, y:7, mx:8'h99, my:8'h99, pulse:0, cnt:5, idx:-1, mem:16'h0};

    reset = 1'b1;
    enable = 1'b0;
    Slow_clk = 1'b0;
    width = 8'd0;
    height = 8'd0;
    bus.Vector_sig = 1'b0;
    bus.mv_x = '0;
    bus.mv_y = '0;
    bus.addr_x = '0;
    bus.addr_y = '0;
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    model_start(0, 0);

    #12;
    check("rst_nxt", 32'(bus.Nxt_block_sig), 0);
    check("rst_done", 32'(bus.MVF_complete_sig), 0);
    check("rst_count", 32'(dut.count), 0);
    reset = 1'b0;
    step();

    // Out-of-range dimensions keep the block idle.
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      width  = (k == 0) ? 8'd0 : (k == 1) ? 8'd17 : 8'd5;
      height = (k == 2) ? 8'd0 : (k == 3) ? 8'd17 : 8'd5;
      step();
      step();
      check($sformatf("baddim%0d_nxt", k), 32'(bus.Nxt_block_sig), 0);
    end

    // Directed vectors on a 5x5 field.
    start_field(5, 5, "f5");
    for (int i = 0; i < 9; i++) begin
      void'(model_vec(tbl[i].x, tbl[i].y, tbl[i].mx, tbl[i].my));
      drive_vec(tbl[i].x, tbl[i].y, tbl[i].mx, tbl[i].my);
      step();
      check($sformatf("tbl%0d_pulse", i), 32'(bus.Nxt_block_sig), 32'(tbl[i].pulse));
      check($sformatf("tbl%0d_count", i), 32'(dut.count), 32'(tbl[i].cnt));
      if (tbl[i].idx >= 0)
        check($sformatf("tbl%0d_mem", i), 32'(dut.mvf_mem[tbl[i].idx]), 32'(tbl[i].mem));
      bus.Vector_sig = 1'b0;
      step();
      check($sformatf("tbl%0d_gap", i), 32'(bus.Nxt_block_sig), 0);
    end

    // Strobe held high for five cycles counts once.
    void'(model_vec(2, 3, 8'h11, 8'h22));
    drive_vec(2, 3, 8'h11, 8'h22);
    step();
    check("hold_first", 32'(bus.Nxt_block_sig), 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(bus.Nxt_block_sig);
    end
    check("hold_extra_pulses", 32'(pulses), 0);
    check("hold_count", 32'(dut.count), 6);
    bus.Vector_sig = 1'b0;
    step();

    // Acceptance coinciding with enable low is discarded.
    send_vec(3, 3, 8'h33, 8'h44, "pre_en", got);
    drive_vec(3, 3, 8'h99, 8'h99);
    enable = 1'b0;
    step();
    check("en_win_nxt", 32'(bus.Nxt_block_sig), 0);
    check("en_win_mem", 32'(dut.mvf_mem[51]), 32'(16'h3344));
    bus.Vector_sig = 1'b0;
    step();
    check("en_win_done", 32'(bus.MVF_complete_sig), 0);

    // Largest grid accepts its corner block and rejects column 16.
    start_field(16, 16, "f16");
    send_vec(15, 15, 8'h5a, 8'ha5, "f16_corner", got);
    send_vec(16, 0, 8'h01, 8'h02, "f16_oor", got);

    // Fresh 5x5 field filled completely.
    start_field(5, 5, "full");
    pulses = 0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        send_vec(x, y, 8'(x * 7 + 1), 8'(y * 13 + 2), $sformatf("full_%0d_%0d", x, y), got);
        pulses += int'(got);
      end
    check("full_pulses", 32'(pulses), 24);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("full_hold%0d", i), 32'(bus.MVF_complete_sig), 1);
    end
    send_vec(0, 0, 8'hee, 8'hee, "done_ignore", got);
    check("done_ignore_mem", 32'(dut.mvf_mem[0]), 32'(m_mem[0]));
    enable = 1'b0;
    #1;
    check("done_before_edge", 32'(bus.MVF_complete_sig), 1);
    step();
    check("done_drop", 32'(bus.MVF_complete_sig), 0);

    // Reset ten vectors into a field.
    start_field(5, 5, "rst");
    for (int i = 0; i < 9; i++) send_vec(i % 5, i / 5, 8'(i), 8'(i + 1), $sformatf("rst_v%0d", i), got);
    void'(model_vec(4, 1, 8'h44, 8'h11));
    drive_vec(4, 1, 8'h44, 8'h11);
    step();
    check("rst_v9_pulse", 32'(bus.Nxt_block_sig), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_nxt", 32'(bus.Nxt_block_sig), 0);
    check("async_rst_done", 32'(bus.MVF_complete_sig), 0);
    check("async_rst_count", 32'(dut.count), 0);
    bus.Vector_sig = 1'b0;
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    start_field(5, 5, "after");
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      send_vec(i % 5, i / 5, 8'(i + 100), 8'(i + 50), $sformatf("after_v%0d", i), got);
      pulses += int'(got);
    end
    check("after_pulses", 32'(pulses), 24);
    check("after_done", 32'(bus.MVF_complete_sig), 1);

    // Randomized fields, including out-of-range and duplicate addresses.
    for (int it = 0; it < 4; it++) begin
      w = int'($urandom_range(1, 6));
      h = int'($urandom_range(1, 6));
      start_field(w, h, $sformatf("rnd%0d", it));
      for (int n = 0; n < 400 && !m_done; n++)
        send_vec(int'($urandom_range(0, w)), int'($urandom_range(0, h)),
                 8'($urandom), 8'($urandom), $sformatf("rnd%0d_v%0d", it, n), got);
      check($sformatf("rnd%0d_complete", it), 32'(bus.MVF_complete_sig), 1);
    end

    // Every vector the model stored must be in the DUT memory.
    for (int i = 0; i < 256; i++)
      if (m_known[i]) check($sformatf("mem%0d", i), 32'(dut.mvf_mem[i]), 32'(m_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pbmve_top.md
# pbmve_top

Motion-vector-field (MVF) collection block at the top of the PBMVE datapath. It accepts one motion vector per picture block over a width × height block grid and stores each vector at its block address. It requests each next block with `Nxt_block_sig` and flags a complete field with `MVF_complete_sig` once every grid position holds a vector.

## Interface
Parameters:
- `MAX_DIM`, 16: maximum grid width/height in blocks; storage is `MAX_DIM*MAX_DIM` entries.
- `MV_W`, 8: width of each motion-vector component.

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; low forces return to IDLE (synchronous).
- `Slow_clk`  in  1  pacing strobe, sampled in the `CLK` domain; not a clock.
- `height`  in  8  grid height in blocks (valid 1..MAX_DIM).
- `width`  in  8  grid width in blocks (valid 1..MAX_DIM).
- `Vector_sig`  in  1  vector-valid strobe; acceptance on its sampled rising edge.
- `mv_x`  in  8  horizontal motion component, two's complement.
- `addr_x`  in  8  block column.
- `mv_y`  in  8  vertical motion component, two's complement.
- `addr_y`  in  8  block row.
- `Nxt_block_sig`  out  1  one-CLK pulse requesting the next vector.
- `MVF_complete_sig`  out  1  level; field complete.

## Operation
- Storage:
  - `mvf_mem` holds 256 × 16 bits, `{mv_x, mv_y}`, at index `addr_y*16+addr_x`.
  - `valid` is a 256-bit bitmap.
  - `count` is 9 bits.
- `Vector_sig` is registered each cycle as `vs_q`. An acceptance event is `Vector_sig & ~vs_q`, so a multi-cycle high level counts once.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - `valid` and `count` are cleared; `mvf_mem` is retained.
  - Goes to COLLECT when `enable`=1, `width` is in 1..16, and `height` is in 1..16.
  - Dimensions are latched on entry. Out-of-range dimensions keep the block in IDLE.
  - Entry issues one `Nxt_block_sig` pulse (request for the first block).
- COLLECT, on an acceptance event with `addr_x`<W and `addr_y`<H:
  - Write `mvf_mem`.
  - If `valid` was 0 for that address: set it and increment `count`.
  - If the new `count` equals W*H: go to DONE with no `Nxt_block_sig`. Otherwise issue a `Nxt_block_sig` pulse.
- A duplicate address overwrites the stored vector, does not increment `count`, and still pulses `Nxt_block_sig`.
- An out-of-range address is ignored: no write, no count, no pulse.
- DONE: `MVF_complete_sig`=1. Further `Vector_sig` events are ignored. Stays in DONE while `enable`=1.
- `enable`=0 in any state: IDLE at the next edge; outputs low.

## Timing
- Reset values: state IDLE, `Nxt_block_sig`=0, `MVF_complete_sig`=0, `vs_q`=0, `count`=0, `valid`=0.
- Acceptance is sampled at edge N, where `Vector_sig`=1 and `vs_q`=0. The memory write and `count` update take effect at edge N.
- `Nxt_block_sig` is registered: high from edge N to edge N+1 (unpaced build).
- `MVF_complete_sig` rises at edge N for the final vector, one cycle latency.
- IDLE→COLLECT transition at edge M; first-request `Nxt_block_sig` is high M..M+1.
- Reset asserted mid-collection clears everything immediately, asynchronously.
- An acceptance event and `enable`=0 in the same cycle: `enable` wins; the vector is discarded.

## Configuration
- `PBMVE_SLOW_PACE_EN` defined:
  - `Slow_clk` passes through a 2-flop synchronizer and rising-edge detector to form `slow_tick`.
  - A pending `Nxt_block_sig` request (from entry or acceptance) is held and emitted as a one-CLK pulse in the cycle after the next `slow_tick`.
  - A new acceptance while a request is pending does not queue a second pulse.
- Undefined: `Slow_clk` is ignored; pulses are issued as in Timing.

## Test plan
- Reset, then `enable`=1 with `width`=`height`=5 → one `Nxt_block_sig` pulse within 2 cycles of `enable`; `MVF_complete_sig`=0.
- `mv_x`=1, `addr_x`=1, `mv_y`=1, `addr_y`=1, `Vector_sig` high for 1 cycle → `mvf_mem[17]`=16'h0101; `count`=1; one `Nxt_block_sig` pulse.
- Hold `Vector_sig` high for 5 cycles → exactly one acceptance and one pulse.
- Same address sent twice → `count` unchanged on the second; stored value updated; pulse issued. `addr_x`=5 with W=5 → ignored, no pulse.
- All 25 addresses written with W=H=5 → 24 acceptance pulses; `MVF_complete_sig` rises one cycle after the 25th, with no pulse; holds until `enable`=0, then low next cycle.
- `reset` asserted mid-field (10 vectors in) → outputs 0 immediately. After re-enable, 25 new vectors are required for completion.
